port_out_uart_tx: RTL and testbench



---
 rtl/port_out_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_port_out_uart_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/port_out_uart_tx.sv
// Watches the CPU output port and sends each new value over 8N1 UART as a line of
// uppercase hex digits followed by CR LF. Changes made while a line is in flight are coalesced.
module port_out_uart_tx #(
    parameter int unsigned WIDTH_REG = 32,
    parameter int unsigned DIVISOR   = 434
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH_REG-1:0] port_in,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [7:0]           skip_count
);

    localparam int unsigned N  = WIDTH_REG / 4;
    localparam int unsigned CW = $clog2(N + 2);
    localparam int unsigned BW = $clog2(DIVISOR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_REG-1:0] last_sent_q, last_sent_d;
    logic [WIDTH_REG-1:0] prev_in_q;
    logic [WIDTH_REG-1:0] snapshot_q, snapshot_d;
    logic [CW-1:0]        char_idx_q, char_idx_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [7:0]           skip_q, skip_d;

    // ASCII character at position idx of the line for value v.
    function automatic logic [7:0] line_char(input logic [WIDTH_REG-1:0] v, input logic [CW-1:0] idx);
        logic [WIDTH_REG-1:0] sh;
        logic [3:0]           nib;
        sh  = '0;
        nib = 4'h0;
        if (idx == CW'(N)) begin
            line_char = 8'h0D;
        end else if (idx == CW'(N + 1)) begin
            line_char = 8'h0A;
        end else begin
            sh        = v >> (4 * (N - 1 - 32'(idx)));
            nib       = sh[3:0];
            line_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            last_sent_q <= '0;
            prev_in_q   <= '0;
            snapshot_q  <= '0;
            char_idx_q  <= '0;
            bit_idx_q   <= '0;
            baud_q      <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            skip_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_sent_q <= last_sent_d;
            prev_in_q   <= port_in;
            snapshot_q  <= snapshot_d;
            char_idx_q  <= char_idx_d;
            bit_idx_q   <= bit_idx_d;
            baud_q      <= baud_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            skip_q      <= skip_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_sent_d = last_sent_q;
        snapshot_d  = snapshot_q;
        char_idx_d  = char_idx_q;
        bit_idx_d   = bit_idx_q;
        baud_d      = baud_q;
        shift_d     = shift_q;
        skip_d      = skip_q;

        // Changes seen while a line is in flight are lost; count them, saturating.
        if (busy_q && (port_in != prev_in_q) && (skip_q != 8'hFF)) begin
            skip_d = skip_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (port_in != last_sent_q) begin
                    state_d     = S_START;
                    snapshot_d  = port_in;
                    last_sent_d = port_in;
                    char_idx_d  = '0;
                    baud_d      = BW'(DIVISOR - 1);
                    shift_d     = line_char(port_in, CW'(0));
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    baud_d    = BW'(DIVISOR - 1);
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    shift_d = shift_q >> 1;
                    baud_d  = BW'(DIVISOR - 1);
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    baud_d = BW'(DIVISOR - 1);
                    if (char_idx_q == CW'(N + 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_START;
                        char_idx_d = char_idx_q + CW'(1);
                        shift_d    = line_char(snapshot_q, char_idx_q + CW'(1));
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level and busy are registered from the next state.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign skip_count = skip_q;

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Directed bench for port_out_uart_tx with an 8-bit port and 4 clocks per bit.
module tb_port_out_uart_tx;

    localparam int WIDTH_REG = 8;
    localparam int DIVISOR   = 4;
    localparam int CHAR_CLKS = 10 * DIVISOR;
    localparam int LINE_CLKS = 4 * CHAR_CLKS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] port_in = 8'h00;
    logic       uart_tx;
    logic       busy;
    logic [7:0] skip_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    port_out_uart_tx #(
        .WIDTH_REG(WIDTH_REG),
        .DIVISOR  (DIVISOR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .port_in   (port_in),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .skip_count(skip_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every clock of one line "c0 c1 CR LF"; optionally disturbs port_in mid-line.
    task automatic check_line(input logic [7:0] c0, input logic [7:0] c1, input bit disturb);
        logic [7:0] chars [4];
        logic [7:0] cur;
        logic       exp_bit;
        int         ch;
        int         b;
        chars[0] = c0;
        chars[1] = c1;
        chars[2] = 8'h0D;
        chars[3] = 8'h0A;
        for (int c = 0; c < LINE_CLKS; c++) begin
            tick();
            ch  = c / CHAR_CLKS;
            b   = (c % CHAR_CLKS) / DIVISOR;
            cur = chars[ch];
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = cur[b-1];
            chk("line_tx", 32'(uart_tx), 32'(exp_bit));
            chk("line_busy", 32'(busy), 32'd1);
            if (disturb) begin
                case (c)
                    10:      port_in = 8'h02;
                    50:      port_in = 8'h03;
                    90:      port_in = 8'h04;
                    default: ;
                endcase
            end
        end
        tick();
        chk("line_end_busy", 32'(busy), 32'd0);
        chk("line_end_tx", 32'(uart_tx), 32'd1);
    endtask

    initial begin
        bit done;

        reset_n = 1'b0;
        port_in = 8'h00;
        repeat (3) tick();
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_skip", 32'(skip_count), 32'd0);
        reset_n = 1'b1;

        // Port held at its reset value never triggers a line.
        for (int i = 0; i < 500; i++) begin
            tick();
            if (i % 50 == 49) begin
                chk("quiet_tx", 32'(uart_tx), 32'd1);
                chk("quiet_busy", 32'(busy), 32'd0);
                chk("quiet_skip", 32'(skip_count), 32'd0);
            end
        end

        port_in = 8'h3A;
        check_line(8'h33, 8'h41, 1'b0);
        chk("skip_after_3a", 32'(skip_count), 32'd0);

        // Three changes during a line: only the last one is sent, right after the gap.
        port_in = 8'h01;
        check_line(8'h30, 8'h31, 1'b1);
        chk("skip_coalesce", 32'(skip_count), 32'd3);
        check_line(8'h30, 8'h34, 1'b0);
        chk("skip_after_04", 32'(skip_count), 32'd3);
        repeat (20) tick();
        chk("no_retrigger_busy", 32'(busy), 32'd0);

        port_in = 8'h80;
        for (int i = 0; i < 400; i++) begin
            tick();
            port_in = port_in ^ 8'hFF;
        end
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("sat_idle_reached", 32'(done), 32'd1);
        chk("skip_saturated", 32'(skip_count), 32'd255);

        // Start 0x5F, then reset while a zero data bit of '5' is on the line.
        port_in = 8'h5F;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) chk("5f_busy_rise", 32'(busy), 32'd1);
            if (c == 9) chk("5f_mid_data_tx", 32'(uart_tx), 32'd0);
        end
        chk("skip_before_reset", 32'(skip_count), 32'd255);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(uart_tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_skip", 32'(skip_count), 32'd0);
        tick();
        chk("held_rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        check_line(8'h35, 8'h46, 1'b0);
        chk("skip_after_5f", 32'(skip_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
